// File: rtl/seg_label_colorizer.sv
// seg_label_colorizer: raster-scans the label buffer, maps class IDs to RGB and streams pixels
// over valid/ready with frame/line markers. Define CLASS_HIST_EN to build the per-class histogram.
module seg_label_colorizer #(
   parameter int unsigned INPUT_WIDTH  = 224,
   parameter int unsigned INPUT_HEIGHT = 224,
   parameter int unsigned NUM_CLASSES  = 21,
   parameter int unsigned ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              lbl_rd_en,
   output logic [ADDR_W-1:0] lbl_addr,
   input  logic [7:0]        lbl_rd_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [23:0]       pix_data,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic              busy,
   output logic              done,
   input  logic [7:0]        hist_sel,
   output logic [15:0]       hist_count
);

   localparam int unsigned PIX_N = INPUT_WIDTH * INPUT_HEIGHT;
   localparam int unsigned X_W   = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
`ifdef CLASS_HIST_EN
   localparam int unsigned ENT_W = 35;
`else
   localparam int unsigned ENT_W = 27;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [X_W-1:0]    x_q, x_d;
   logic              dvalid_q, dvalid_d;
   logic [2:0]        dmeta_q, dmeta_d;
   logic              head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
   logic [ENT_W-1:0]  head_q, head_d, skid_q, skid_d, push_ent;
   logic              start_acc, beat, last_rd;
   logic [1:0]        fill;

   function automatic logic [23:0] colorize(input logic [7:0] id);
      logic [15:0] id_w;
      id_w = 16'(id);
      if (id >= 8'(NUM_CLASSES)) return 24'h000000;
      return {8'(id_w * 16'd37), 8'(id_w * 16'd71), 8'(id_w * 16'd113)};
   endfunction

   assign start_acc = (state_q == S_IDLE) && start;
   assign beat      = head_valid_q && pix_ready;
   // Entries that will still be held once the returning read lands, after this cycle's beat leaves.
   assign fill      = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(dvalid_q) - 2'(beat);
   assign lbl_rd_en = (state_q == S_RUN) && (fill < 2'd2);
   assign last_rd   = lbl_rd_en && (addr_q == ADDR_W'(PIX_N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_rd) state_d = S_DRAIN;
         S_DRAIN: if (beat && head_q[0]) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      if ((state_d == S_RUN) || (state_d == S_DRAIN)) busy_d = 1'b1;
      if (state_d == S_DONE) done_d = 1'b1;
   end

   // Read-address generation and marker tagging of each issued read.
   always_comb begin
      addr_d   = addr_q;
      x_d      = x_q;
      dvalid_d = lbl_rd_en;
      dmeta_d  = dmeta_q;
      if (start_acc) begin
         addr_d = '0;
         x_d    = '0;
      end else if (lbl_rd_en) begin
         dmeta_d = {addr_q == '0, x_q == X_W'(INPUT_WIDTH - 1), last_rd};
         if (!last_rd) addr_d = addr_q + ADDR_W'(1);
         x_d = (x_q == X_W'(INPUT_WIDTH - 1)) ? '0 : x_q + X_W'(1);
      end
   end

`ifdef CLASS_HIST_EN
   assign push_ent = {lbl_rd_data, colorize(lbl_rd_data), dmeta_q};
`else
   assign push_ent = {colorize(lbl_rd_data), dmeta_q};
`endif

   // Two-entry output FIFO: head drives the port, skid absorbs the read landing during a stall.
   always_comb begin
      head_valid_d = head_valid_q;
      head_d       = head_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (!head_valid_q || beat) begin
         if (skid_valid_q) begin
            head_valid_d = 1'b1;
            head_d       = skid_q;
            skid_valid_d = dvalid_q;
            if (dvalid_q) skid_d = push_ent;
         end else begin
            head_valid_d = dvalid_q;
            if (dvalid_q) head_d = push_ent;
         end
      end else if (dvalid_q) begin
         skid_valid_d = 1'b1;
         skid_d       = push_ent;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         x_q          <= '0;
         dvalid_q     <= 1'b0;
         dmeta_q      <= '0;
         head_valid_q <= 1'b0;
         head_q       <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
      end else begin
         addr_q       <= addr_d;
         x_q          <= x_d;
         dvalid_q     <= dvalid_d;
         dmeta_q      <= dmeta_d;
         head_valid_q <= head_valid_d;
         head_q       <= head_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
      end
   end

   assign lbl_addr  = addr_q;
   assign pix_valid = head_valid_q;
   assign pix_data  = head_q[26:3];
   assign pix_sof   = head_q[2];
   assign pix_eol   = head_q[1];
   assign pix_eof   = head_q[0];
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef CLASS_HIST_EN
   logic [15:0] hist_q [NUM_CLASSES];
   logic [15:0] hist_d [NUM_CLASSES];

   // Bins clear on an accepted start and count accepted in-range beats.
   always_comb begin
      hist_d = hist_q;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
         if (start_acc) hist_d[i] = '0;
         else if (beat && (head_q[34:27] == 8'(i))) hist_d[i] = hist_q[i] + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CLASSES; i++) hist_q[i] <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   always_comb begin
      hist_count = '0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
         if (hist_sel == 8'(i)) hist_count = hist_q[i];
      end
   end
`else
   logic unused_hist_sel;
   assign unused_hist_sel = &{1'b0, hist_sel};
   assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_seg_label_colorizer.sv
// Directed bench for seg_label_colorizer on a 4x2 frame: latency, markers, palette, back-pressure,
// start filtering, mid-frame reset and (with CLASS_HIST_EN) the class histogram.
`timescale 1ns/1ps
module tb_seg_label_colorizer;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;
   localparam int unsigned N  = W * H;
   localparam int unsigned NC = 21;
   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          lbl_rd_en;
   logic [AW-1:0] lbl_addr;
   logic [7:0]    lbl_rd_data = 8'h00;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic [23:0]   pix_data;
   logic          pix_sof, pix_eol, pix_eof, busy, done;
   logic [7:0]    hist_sel = 8'h00;
   logic [15:0]   hist_count;

   seg_label_colorizer #(
      .INPUT_WIDTH(W), .INPUT_HEIGHT(H), .NUM_CLASSES(NC), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .lbl_rd_en(lbl_rd_en), .lbl_addr(lbl_addr), .lbl_rd_data(lbl_rd_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
      .busy(busy), .done(done), .hist_sel(hist_sel), .hist_count(hist_count)
   );

   always #5 clk = ~clk;

   // Label buffer: data one cycle after the strobe, junk otherwise.
   logic [7:0] mem [N];
   always @(posedge clk) lbl_rd_data <= lbl_rd_en ? mem[lbl_addr] : 8'hEE;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] exp_color(input int id);
      if (id >= int'(NC)) return 24'h000000;
      return {8'((id * 37) % 256), 8'((id * 71) % 256), 8'((id * 113) % 256)};
   endfunction

   // Monitor state, sampled on the falling edge.
   int            cyc = 0, rd_cnt = 0, beat_cnt = 0, max_out = 0, hold_err = 0;
   int            done_cnt = 0, done_cyc = 0, first_rd_cyc = -1, first_valid_cyc = -1;
   logic          busy_at_done = 1'b0;
   logic          prev_stall = 1'b0;
   logic [26:0]   prev_out = '0;
   logic [23:0]   bq_data [$];
   logic [2:0]    bq_mark [$];
   int            bq_cyc [$];
   logic [AW-1:0] rd_addrs [$];

   always @(negedge clk) begin
      cyc++;
      if (rd_cnt - beat_cnt > max_out) max_out = rd_cnt - beat_cnt;
      if (prev_stall && ({pix_valid, pix_data, pix_sof, pix_eol, pix_eof} != {1'b1, prev_out}))
         hold_err++;
      prev_stall = pix_valid && !pix_ready;
      prev_out   = {pix_data, pix_sof, pix_eol, pix_eof};
      if (lbl_rd_en) begin
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         rd_addrs.push_back(lbl_addr);
         rd_cnt++;
      end
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pix_valid && pix_ready) begin
         bq_data.push_back(pix_data);
         bq_mark.push_back({pix_sof, pix_eol, pix_eof});
         bq_cyc.push_back(cyc);
         beat_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
   end

   // Ready pattern: mode 0 always ready, mode 1 toggles and then stalls for 5 cycles.
   int rmode = 0, rbase = 0;
   initial forever begin
      int r;
      @(posedge clk);
      #1;
      r = cyc - rbase;
      if (rmode == 0) pix_ready = 1'b1;
      else pix_ready = (r >= 6 && r < 11) ? 1'b0 : (r % 2 == 0);
   end

   task automatic clear_frame();
      bq_data.delete(); bq_mark.delete(); bq_cyc.delete(); rd_addrs.delete();
      rd_cnt = 0; beat_cnt = 0; max_out = 0; hold_err = 0; done_cnt = 0; done_cyc = 0;
      first_rd_cyc = -1; first_valid_cyc = -1; prev_stall = 1'b0;
   endtask

   task automatic start_frame(output int acc);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      acc   = cyc + 1;
      rbase = cyc;
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
      repeat (3) @(posedge clk);
   endtask

   task automatic verify_frame(input string tag, input int acc, input bit full_rate);
      int aerr = 0;
      check({tag, "_beats"}, 32'(bq_data.size()), 32'(N));
      for (int i = 0; i < bq_data.size() && i < int'(N); i++) begin
         check($sformatf("%s_data%0d", tag, i), 32'(bq_data[i]), 32'(exp_color(int'(mem[i]))));
         check($sformatf("%s_mark%0d", tag, i), 32'(bq_mark[i]),
               32'({i == 0, (i % int'(W)) == int'(W) - 1, i == int'(N) - 1}));
      end
      for (int i = 0; i < rd_addrs.size(); i++) if (rd_addrs[i] != AW'(i)) aerr++;
      check({tag, "_reads"}, 32'(rd_addrs.size()), 32'(N));
      check({tag, "_addr_seq_err"}, 32'(aerr), 32'd0);
      check({tag, "_rd_lat"}, 32'(first_rd_cyc), 32'(acc));
      check({tag, "_valid_lat"}, 32'(first_valid_cyc), 32'(acc + 2));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      check({tag, "_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
      check({tag, "_hold_err"}, 32'(hold_err), 32'd0);
      if (bq_cyc.size() == int'(N)) begin
         check({tag, "_done_after_eof"}, 32'(done_cyc - bq_cyc[N-1]), 32'd1);
         if (full_rate) check({tag, "_back_to_back"}, 32'(bq_cyc[N-1] - bq_cyc[0]), 32'(N - 1));
      end
   endtask

   initial begin
      int acc, n;
      int unsigned sum;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_rd_en", 32'(lbl_rd_en), 32'd0);
      check("rst_busy_done", 32'({busy, done}), 32'd0);
      check("rst_data", 32'(pix_data), 32'd0);
      check("rst_addr", 32'(lbl_addr), 32'd0);
      check("rst_marks", 32'({pix_sof, pix_eol, pix_eof}), 32'd0);
      rst_n = 1'b1;

      // 1: labels 0..7 at full rate
      for (int i = 0; i < int'(N); i++) mem[i] = 8'(i);
      rmode = 0;
      clear_frame();
      start_frame(acc);
      wait_done("t1");
      verify_frame("t1", acc, 1'b1);
      if (bq_data.size() > 1) check("t1_id1_color", 32'(bq_data[1]), 32'h00254771);

      // 2: back-pressure
      rmode = 1;
      clear_frame();
      start_frame(acc);
      wait_done("t2");
      verify_frame("t2", acc, 1'b0);
      rmode = 0;

      // 3: out-of-range class
      mem[2] = 8'd25;
      clear_frame();
      start_frame(acc);
      wait_done("t3");
      verify_frame("t3", acc, 1'b1);
      if (bq_data.size() > 2) check("t3_px2_black", 32'(bq_data[2]), 32'd0);
`ifdef CLASS_HIST_EN
      sum = 0;
      for (int k = 0; k < int'(NC); k++) begin
         hist_sel = 8'(k);
         #1 sum += hist_count;
      end
      check("t3_hist_sum", 32'(sum), 32'd7);
`endif

      // 4: start during RUN and on the done cycle is ignored; start one cycle later is taken
      for (int i = 0; i < int'(N); i++) mem[i] = 8'(i);
      clear_frame();
      start_frame(acc);
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t4_done_wait", 32'(done), 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("t4_ign_busy", 32'(busy), 32'd0);
      check("t4_ign_rd", 32'(lbl_rd_en), 32'd0);
      verify_frame("t4a", acc, 1'b1);
      clear_frame();
      start = 1'b1;
      @(posedge clk);
      acc   = cyc + 1;
      rbase = cyc;
      #1 start = 1'b0;
      wait_done("t4b");
      verify_frame("t4b", acc, 1'b1);

      // 5: reset mid-frame after beat 3
      clear_frame();
      start_frame(acc);
      n = 0;
      while (bq_data.size() < 4 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("t5_beats_before_rst", 32'(bq_data.size()), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(pix_valid), 32'd0);
      check("t5_rst_rd_en", 32'(lbl_rd_en), 32'd0);
      check("t5_rst_busy_done", 32'({busy, done}), 32'd0);
      check("t5_rst_data", 32'(pix_data), 32'd0);
      check("t5_rst_addr", 32'(lbl_addr), 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_post_valid", 32'(pix_valid), 32'd0);
      check("t5_no_done", 32'(done_cnt), 32'd0);
      clear_frame();
      start_frame(acc);
      wait_done("t5");
      verify_frame("t5", acc, 1'b1);

      // 6: histogram
      mem[0] = 8'd3; mem[1] = 8'd3; mem[2] = 8'd3; mem[3] = 8'd0;
      mem[4] = 8'd20; mem[5] = 8'd20; mem[6] = 8'd1; mem[7] = 8'd3;
      clear_frame();
      start_frame(acc);
      wait_done("t6");
      verify_frame("t6", acc, 1'b1);
`ifdef CLASS_HIST_EN
      hist_sel = 8'd3;  #1 check("t6_hist3", 32'(hist_count), 32'd4);
      hist_sel = 8'd20; #1 check("t6_hist20", 32'(hist_count), 32'd2);
      hist_sel = 8'd0;  #1 check("t6_hist0", 32'(hist_count), 32'd1);
      hist_sel = 8'd1;  #1 check("t6_hist1", 32'(hist_count), 32'd1);
      hist_sel = 8'd21; #1 check("t6_hist21", 32'(hist_count), 32'd0);
`else
      hist_sel = 8'd3;  #1 check("t6_hist_tied", 32'(hist_count), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
